// File: rtl/rgb_pwm_driver_pkg.sv
// Shared defaults, channel indices and small helpers for the RGB PWM driver.
package rgb_pwm_driver_pkg;

  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_PRESCALE = 4;
  localparam int DEF_MAX_DUTY = 255;

  localparam int NUM_CH   = 3;
  localparam int CH_RED   = 0;
  localparam int CH_GREEN = 1;
  localparam int CH_BLUE  = 2;

  // A prescaler of 1 still needs a 1-bit counter that simply never leaves 0.
  function automatic int presc_width(input int presc);
    return (presc > 1) ? $clog2(presc) : 1;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One PWM lane: clamps a pending duty on load, holds the active duty and
// drives a registered compare output against the shared phase counter.
module pwm_channel
  import rgb_pwm_driver_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int MAX_DUTY = DEF_MAX_DUTY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic [PWM_BITS-1:0] i_phase,
  output logic                o_led
);

  // A ceiling at or above full scale means no clamping at all.
  localparam logic [PWM_BITS-1:0] CLAMP =
    (MAX_DUTY >= (1 << PWM_BITS) - 1) ? {PWM_BITS{1'b1}} : PWM_BITS'(MAX_DUTY);

  logic [PWM_BITS-1:0] r_active;
  logic [PWM_BITS-1:0] w_clamped;
  logic                r_led;

  assign w_clamped = (i_duty > CLAMP) ? CLAMP : i_duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= '0;
      r_led    <= 1'b0;
    end else begin
      if (i_load) begin
        r_active <= w_clamped;
      end
      r_led <= (i_phase < r_active);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB PWM stage: prescaler, phase counter and a one-deep colour buffer that is
// only applied at a period boundary, feeding three pwm_channel lanes.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int MAX_DUTY = DEF_MAX_DUTY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PWM_BITS-1:0] in_red,
  input  logic [PWM_BITS-1:0] in_green,
  input  logic [PWM_BITS-1:0] in_blue,
  output logic                LED_RED,
  output logic                LED_GREEN,
  output logic                LED_BLUE,
  output logic                frame_start
);

  localparam int PS_W = presc_width(PRESCALE);

  logic [PS_W-1:0]     r_presc;
  logic [PWM_BITS-1:0] r_phase;
  logic                r_pend_full;
  logic                r_frame_start;
  logic [PWM_BITS-1:0] w_in_duty [NUM_CH];
  logic [NUM_CH-1:0]   w_led;
  logic                w_tick;
  logic                w_boundary;
  logic                w_xfer;
  logic                w_load;

  assign w_in_duty[CH_RED]   = in_red;
  assign w_in_duty[CH_GREEN] = in_green;
  assign w_in_duty[CH_BLUE]  = in_blue;

  assign w_tick     = (r_presc == PS_W'(PRESCALE - 1));
  assign w_boundary = w_tick && (r_phase == '1);
  assign in_ready   = ~rst & ~r_pend_full;
  assign w_xfer     = in_valid & in_ready;
  assign w_load     = w_boundary & r_pend_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc       <= '0;
      r_phase       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_phase <= r_phase + 1'b1;
      end
      r_frame_start <= w_boundary;
    end
  end

  // A word can only arrive while the buffer is empty, so a transfer on a
  // boundary fills the buffer and waits for the following boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_full <= 1'b0;
    end else if (w_xfer) begin
      r_pend_full <= 1'b1;
    end else if (w_boundary) begin
      r_pend_full <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PWM_BITS-1:0] r_pend;

      always_ff @(posedge clk) begin
        if (w_xfer) begin
          r_pend <= w_in_duty[gi];
        end
      end

      pwm_channel #(
        .PWM_BITS (PWM_BITS),
        .MAX_DUTY (MAX_DUTY)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_duty  (r_pend),
        .i_phase (r_phase),
        .o_led   (w_led[gi])
      );
    end
  endgenerate

  assign LED_RED     = w_led[CH_RED];
  assign LED_GREEN   = w_led[CH_GREEN];
  assign LED_BLUE    = w_led[CH_BLUE];
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: three configurations checked every cycle against a
// time-based model, plus literal per-period high counts and pulse timings.
module tb_rgb_pwm_driver;

  logic       clk, rst, va, vb;
  logic [7:0] ra, ga, ba;
  logic [3:0] rb, gb, bb;
  logic [2:0] led0, led1, led2, fs, rdy;

  rgb_pwm_driver #(.PWM_BITS(8), .PRESCALE(1), .MAX_DUTY(255)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(rdy[0]),
    .in_red(ra), .in_green(ga), .in_blue(ba),
    .LED_RED(led0[0]), .LED_GREEN(led0[1]), .LED_BLUE(led0[2]), .frame_start(fs[0]));

  rgb_pwm_driver #(.PWM_BITS(8), .PRESCALE(1), .MAX_DUTY(200)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(va), .in_ready(rdy[1]),
    .in_red(ra), .in_green(ga), .in_blue(ba),
    .LED_RED(led1[0]), .LED_GREEN(led1[1]), .LED_BLUE(led1[2]), .frame_start(fs[1]));

  rgb_pwm_driver #(.PWM_BITS(4), .PRESCALE(3), .MAX_DUTY(255)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rdy[2]),
    .in_red(rb), .in_green(gb), .in_blue(bb),
    .LED_RED(led2[0]), .LED_GREEN(led2[1]), .LED_BLUE(led2[2]), .frame_start(fs[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int P[3]  = '{1, 1, 3};
  int NP[3] = '{256, 256, 16};
  int MX[3] = '{255, 200, 255};

  int  total, bad;
  int  ecount, xfer_t;
  int  m_active[3][3], m_pend[3][3];
  bit  m_pfull[3];
  bit  e_led[3][3];
  bit  e_fs[3], e_rdy[3];
  bit  mvalid;
  int  acc[3][3], hi[3][3];
  int  fs_cnt[3], fs_rel[3], fs_at[3][2];
  logic rst_s;

  function automatic int b2i(input logic v);
    return (v === 1'b1) ? 1 : ((v === 1'b0) ? 0 : 2);
  endfunction

  function automatic int dut_led(input int k, input int c);
    case (k)
      0:       return b2i(led0[c]);
      1:       return b2i(led1[c]);
      default: return b2i(led2[c]);
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic chk_cyc(input string name, input int k, input int c, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s k=%0d c=%0d t=%0d got=%0d want=%0d", name, k, c, ecount, got, want);
    end
  endtask

  // Model: phase and boundaries follow directly from cycles since release.
  initial begin
    int ph, din[3];
    bit bnd, v, xf;
    total = 0; bad = 0; ecount = 0; xfer_t = -1; mvalid = 0;
    for (int k = 0; k < 3; k++) begin
      m_pfull[k] = 0; e_fs[k] = 0; e_rdy[k] = 0; fs_cnt[k] = 0; fs_rel[k] = 0;
      fs_at[k][0] = -1; fs_at[k][1] = -1;
      for (int c = 0; c < 3; c++) begin
        m_active[k][c] = 0; m_pend[k][c] = 0; e_led[k][c] = 0; acc[k][c] = 0; hi[k][c] = -1;
      end
    end
    forever begin
      @(posedge clk);
      rst_s = rst;
      if (va === 1'b1 && rdy[0] === 1'b1) xfer_t = ecount;
      for (int k = 0; k < 3; k++) begin
        v = (k < 2) ? va : vb;
        din[0] = (k < 2) ? int'(ra) : int'(rb);
        din[1] = (k < 2) ? int'(ga) : int'(gb);
        din[2] = (k < 2) ? int'(ba) : int'(bb);
        if (rst_s) begin
          m_pfull[k] = 0; e_fs[k] = 0;
          for (int c = 0; c < 3; c++) begin m_active[k][c] = 0; e_led[k][c] = 0; end
        end else begin
          ph  = (ecount / P[k]) % NP[k];
          bnd = (ecount % (P[k] * NP[k])) == (P[k] * NP[k] - 1);
          for (int c = 0; c < 3; c++) e_led[k][c] = (ph < m_active[k][c]);
          e_fs[k] = bnd;
          xf = v && !m_pfull[k];
          if (bnd && m_pfull[k]) begin
            for (int c = 0; c < 3; c++)
              m_active[k][c] = (m_pend[k][c] > MX[k]) ? MX[k] : m_pend[k][c];
            m_pfull[k] = 0;
          end
          if (xf) begin
            for (int c = 0; c < 3; c++) m_pend[k][c] = din[c];
            m_pfull[k] = 1;
          end
        end
        e_rdy[k] = !rst_s && !m_pfull[k];
      end
      ecount = rst_s ? 0 : ecount + 1;
      if (rst_s) mvalid = 1;
      #1;
      if (mvalid) begin
        for (int k = 0; k < 3; k++) begin
          for (int c = 0; c < 3; c++) chk_cyc("led", k, c, dut_led(k, c), int'(e_led[k][c]));
          chk_cyc("frame_start", k, 0, b2i(fs[k]), int'(e_fs[k]));
          chk_cyc("in_ready", k, 0, b2i(rdy[k]), int'(e_rdy[k]));
          if (rst_s) begin
            fs_rel[k] = 0;
            for (int c = 0; c < 3; c++) acc[k][c] = 0;
          end else begin
            for (int c = 0; c < 3; c++) acc[k][c] += (dut_led(k, c) == 1) ? 1 : 0;
            if (fs[k] === 1'b1) begin
              for (int c = 0; c < 3; c++) begin hi[k][c] = acc[k][c]; acc[k][c] = 0; end
              fs_cnt[k]++;
              if (fs_rel[k] < 2) fs_at[k][fs_rel[k]] = ecount;
              fs_rel[k]++;
            end
          end
        end
      end
    end
  end

  task automatic wait_frames(input int k, input int n);
    int target, lim;
    target = fs_cnt[k] + n;
    lim = 0;
    while (fs_cnt[k] < target && lim < 5000) begin
      @(negedge clk);
      lim++;
    end
    if (lim >= 5000) chk("wait_frames_timeout", 0, 1);
  endtask

  task automatic send(input int k, input int r, input int g, input int b);
    int n;
    n = 0;
    if (k == 0) begin va = 1'b1; ra = 8'(r); ga = 8'(g); ba = 8'(b); end
    else begin vb = 1'b1; rb = 4'(r); gb = 4'(g); bb = 4'(b); end
    while (rdy[k] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("send_timeout", 0, 1);
    @(negedge clk);
    if (k == 0) va = 1'b0; else vb = 1'b0;
  endtask

  task automatic chk_hi(input string tag, input int k, input int r, input int g, input int b);
    chk($sformatf("%s_k%0d_red", tag, k), hi[k][0], r);
    chk($sformatf("%s_k%0d_green", tag, k), hi[k][1], g);
    chk($sformatf("%s_k%0d_blue", tag, k), hi[k][2], b);
  endtask

  task automatic wait_phase(input int modv, input int want);
    int n;
    n = 0;
    while ((ecount % modv) != want && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("wait_phase_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; va = 1'b0; vb = 1'b0;
    ra = '0; ga = '0; ba = '0; rb = '0; gb = '0; bb = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after release: pulses at fixed cycle counts, LEDs dark.
    repeat (600) @(negedge clk);
    chk("fs_first_k0", fs_at[0][0], 256);
    chk("fs_second_k0", fs_at[0][1], 512);
    chk("fs_first_k1", fs_at[1][0], 256);
    chk("fs_first_k2", fs_at[2][0], 48);
    chk("fs_second_k2", fs_at[2][1], 96);
    chk_hi("idle", 0, 0, 0, 0);
    $display("idle: first frame_start at %0d, second at %0d", fs_at[0][0], fs_at[0][1]);

    send(2, 5, 0, 15);
    wait_frames(2, 2);
    chk_hi("presc3", 2, 15, 0, 45);
    $display("presc3 duty(5,0,15): high %0d/%0d/%0d", hi[2][0], hi[2][1], hi[2][2]);

    send(0, 0, 128, 255);
    wait_frames(0, 2);
    chk_hi("basic", 0, 0, 128, 255);
    chk_hi("basic", 1, 0, 128, 200);
    $display("basic (0,128,255): high %0d/%0d/%0d", hi[0][0], hi[0][1], hi[0][2]);

    send(0, 10, 20, 30);
    send(0, 40, 50, 60);
    chk("b2b_second_accept_phase", xfer_t % 256, 0);
    wait_frames(0, 1);
    chk_hi("b2b_a", 0, 10, 20, 30);
    wait_frames(0, 1);
    chk_hi("b2b_b", 0, 40, 50, 60);
    $display("back-to-back: B accepted at t=%0d, B high %0d/%0d/%0d", xfer_t, hi[0][0], hi[0][1], hi[0][2]);

    send(0, 255, 201, 200);
    wait_frames(0, 2);
    chk_hi("clamp", 0, 255, 201, 200);
    chk_hi("clamp", 1, 200, 200, 200);
    $display("clamp (255,201,200): max200 high %0d/%0d/%0d", hi[1][0], hi[1][1], hi[1][2]);

    wait_phase(256, 255);
    chk("ready_at_boundary", b2i(rdy[0]), 1);
    va = 1'b1; ra = 8'd60; ga = 8'd70; ba = 8'd80;
    @(negedge clk);
    va = 1'b0;
    chk("boundary_accept_phase", xfer_t % 256, 255);
    wait_frames(0, 1);
    chk_hi("bnd_old", 0, 255, 201, 200);
    chk_hi("bnd_old", 1, 200, 200, 200);
    wait_frames(0, 1);
    chk_hi("bnd_new", 0, 60, 70, 80);
    chk_hi("bnd_new", 1, 60, 70, 80);
    $display("boundary accept: new high %0d/%0d/%0d", hi[0][0], hi[0][1], hi[0][2]);

    wait_phase(256, 10);
    send(0, 90, 90, 90);
    repeat (20) @(negedge clk);
    chk("led_red_before_rst", b2i(led0[0]), 1);
    chk("pending_before_rst", b2i(rdy[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("led_red_after_rst", b2i(led0[0]), 0);
    chk("led_green_after_rst", b2i(led0[1]), 0);
    chk("led_blue_after_rst", b2i(led0[2]), 0);
    chk("ready_in_rst", b2i(rdy[0]), 0);
    rst = 1'b0;
    wait_frames(0, 1);
    chk_hi("post_rst_p1", 0, 0, 0, 0);
    wait_frames(0, 1);
    chk_hi("post_rst_p2", 0, 0, 0, 0);
    $display("reset with pending: period2 high %0d/%0d/%0d", hi[0][0], hi[0][1], hi[0][2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
